mv_select: RTL and testbench
============================

MV_SELECT -- requirements
Module: mv_select

Interface
REQ-001 Parameter NUM_CAND, default 16, meaning SAD candidates per row (horizontal displacements), power of two, ≥2.
REQ-002 Parameter NUM_ROWS, default 16, meaning rows per search window (vertical displacements), power of two, ≥2.
REQ-003 Parameter SAD_W, default 12, meaning width of one SAD value, unsigned.
REQ-004 Derived MVX_W = clog2(NUM_CAND) and MVY_W = clog2(NUM_ROWS); each is 4 at defaults.
REQ-005 Port clk, input, 1, meaning the single clock; every register is clocked on its rising edge.
REQ-006 Port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 Port start, input, 1, meaning a one-cycle pulse that opens a new search window.
REQ-008 Port in_valid, input, 1, meaning sum_row holds one row of SADs.
REQ-009 Port in_ready, output, 1, meaning the block accepts a row this cycle.
REQ-010 Port sum_row, input, NUM_CAND*SAD_W, meaning SAD of candidate k is in bits [k*SAD_W +: SAD_W].
REQ-011 Port out_valid, output, 1, meaning the result fields are valid.
REQ-012 Port out_ready, input, 1, meaning the consumer takes the result.
REQ-013 Port out_mad, output, SAD_W, meaning the minimum SAD in the window.
REQ-014 Port out_mvx, output, MVX_W, meaning the candidate index of that minimum.
REQ-015 Port out_mvy, output, MVY_W, meaning the row index of that minimum.

Function
REQ-016 The FSM SHALL have states IDLE, ACCUM, FLUSH and DONE.
REQ-017 IDLE SHALL go to ACCUM when start=1, clearing the row counter and setting the running minimum to all-ones.
REQ-018 In ACCUM, in_ready SHALL be 1; a beat is accepted when in_valid and in_ready are both 1.
REQ-019 Each accepted beat SHALL increment the row counter; the beat that accepts row NUM_ROWS-1 SHALL move the FSM to FLUSH.
REQ-020 Stage 1 SHALL register the per-row minimum and its candidate index one cycle after acceptance, with the row index captured alongside.
REQ-021 Stage 2 SHALL replace the running {mad,mvx,mvy} only when the stage-1 minimum is strictly less than the running mad.
REQ-022 Tie-break: the lowest candidate index wins within a row, and the earliest row wins across rows.
REQ-023 FLUSH SHALL last until the last row has merged; out_valid SHALL assert exactly 2 cycles after the clock edge that accepts the final row.
REQ-024 DONE SHALL hold out_valid=1 and the result fields stable until out_ready=1, then return to IDLE on that edge.
REQ-025 in_ready SHALL be 0 in IDLE, FLUSH and DONE.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 in_valid gaps in ACCUM SHALL stall the block with no state change.
REQ-028 All comparisons SHALL be unsigned at SAD_W bits; there is no saturation or overflow path.
REQ-029 The result fields SHALL read 0 whenever out_valid=0.

Reset
REQ-030 While rst_n=0, asynchronously: state IDLE, row counter 0, stage-1 valid 0, running minimum all-ones, and out_valid, out_mad, out_mvx, out_mvy, in_ready all 0.
REQ-031 Reset asserted in any state SHALL abort the window; no partial result is ever presented.

Structure
REQ-032 Package fsbm_pkg SHALL hold the state enum, default parameter constants and the clog2 function.
REQ-033 Sub-module argmin_row SHALL be the combinational NUM_CAND-input min/index reduction tree, parameterised by NUM_CAND and SAD_W, with lower-index priority on ties.

Verification
REQ-034 Default parameters, row r holds candidate k = 100+r+k except row 5, k=9 = 3 -> out_mad=3, out_mvx=9, out_mvy=5.
REQ-035 All SADs = 7 -> out_mad=7, out_mvx=0, out_mvy=0 (tie-break).
REQ-036 Minimum value 0 present in both row 2 k=4 and row 11 k=1 -> out_mvx=4, out_mvy=2.
REQ-037 in_valid toggled randomly and out_ready held 0 for 10 cycles -> result identical to the back-to-back run, held stable, and start pulses during DONE ignored.
REQ-038 rst_n pulsed low after row 8 -> outputs 0 immediately; a new start with fresh data yields the correct result.
REQ-039 NUM_CAND=8, NUM_ROWS=4, SAD_W=16, with minimum 16'hFFFE at row 3 k=7 and all others 16'hFFFF -> out_mad=16'hFFFE, out_mvx=7, out_mvy=3.

Source files
------------

// File: rtl/fsbm_pkg.sv
// Shared definitions for the motion-vector selection block: FSM states,
// default geometry of the search window and a constant-foldable clog2.
package fsbm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fsbm_state_e;

    localparam int DEF_NUM_CAND = 16;
    localparam int DEF_NUM_ROWS = 16;
    localparam int DEF_SAD_W    = 12;

    // Ceiling log2; used to size index fields from the window geometry.
    function automatic int fsbm_clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/argmin_row.sv
// Combinational min/argmin over one row of SAD candidates, built as a
// balanced binary tree. On equal values the left (lower-index) operand is
// kept at every node, so the lowest candidate index wins overall.
module argmin_row
    import fsbm_pkg::*;
#(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int SAD_W    = DEF_SAD_W
) (
    input  logic [NUM_CAND*SAD_W-1:0]        sad_row_i,
    output logic [SAD_W-1:0]                 min_o,
    output logic [fsbm_clog2(NUM_CAND)-1:0]  idx_o
);

    localparam int IDX_W = fsbm_clog2(NUM_CAND);
    localparam int LV    = fsbm_clog2(NUM_CAND);

    genvar l, n;
    for (l = 0; l < LV; l++) begin : g_lvl
        localparam int CNT = NUM_CAND >> (l + 1);
        logic [CNT*SAD_W-1:0] v_s;
        logic [CNT*IDX_W-1:0] i_s;
        for (n = 0; n < CNT; n++) begin : g_node
            logic [SAD_W-1:0] a_v_s;
            logic [SAD_W-1:0] b_v_s;
            logic [IDX_W-1:0] a_i_s;
            logic [IDX_W-1:0] b_i_s;
            if (l == 0) begin : g_leaf
                assign a_v_s = sad_row_i[(2*n)*SAD_W +: SAD_W];
                assign b_v_s = sad_row_i[(2*n+1)*SAD_W +: SAD_W];
                assign a_i_s = IDX_W'(2*n);
                assign b_i_s = IDX_W'(2*n+1);
            end else begin : g_inner
                assign a_v_s = g_lvl[l-1].v_s[(2*n)*SAD_W +: SAD_W];
                assign b_v_s = g_lvl[l-1].v_s[(2*n+1)*SAD_W +: SAD_W];
                assign a_i_s = g_lvl[l-1].i_s[(2*n)*IDX_W +: IDX_W];
                assign b_i_s = g_lvl[l-1].i_s[(2*n+1)*IDX_W +: IDX_W];
            end
            // Right operand only wins when strictly smaller: ties keep the lower index.
            assign v_s[n*SAD_W +: SAD_W] = (b_v_s < a_v_s) ? b_v_s : a_v_s;
            assign i_s[n*IDX_W +: IDX_W] = (b_v_s < a_v_s) ? b_i_s : a_i_s;
        end
    end

    assign min_o = g_lvl[LV-1].v_s;
    assign idx_o = g_lvl[LV-1].i_s;

endmodule

// File: rtl/mv_select.sv
// Motion-vector selection: accepts one row of SADs per beat, reduces each
// row to its minimum (stage 1), merges it into a running window minimum
// (stage 2) and presents {mad, mvx, mvy} once the whole window is merged.
module mv_select
    import fsbm_pkg::*;
#(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int SAD_W    = DEF_SAD_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_CAND*SAD_W-1:0]        sum_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [SAD_W-1:0]                 out_mad,
    output logic [fsbm_clog2(NUM_CAND)-1:0]  out_mvx,
    output logic [fsbm_clog2(NUM_ROWS)-1:0]  out_mvy
);

    localparam int MVX_W = fsbm_clog2(NUM_CAND);
    localparam int MVY_W = fsbm_clog2(NUM_ROWS);
    localparam logic [MVY_W-1:0] LAST_ROW = MVY_W'(NUM_ROWS - 1);
    localparam logic [SAD_W-1:0] SAD_MAX  = {SAD_W{1'b1}};

    fsbm_state_e       state_q,     state_d;
    logic [MVY_W-1:0]  row_cnt_q,   row_cnt_d;
    logic              in_ready_q,  in_ready_d;
    logic              s1_valid_q,  s1_valid_d;
    logic [SAD_W-1:0]  s1_min_q,    s1_min_d;
    logic [MVX_W-1:0]  s1_idx_q,    s1_idx_d;
    logic [MVY_W-1:0]  s1_row_q,    s1_row_d;
    logic [SAD_W-1:0]  run_mad_q,   run_mad_d;
    logic [MVX_W-1:0]  run_mvx_q,   run_mvx_d;
    logic [MVY_W-1:0]  run_mvy_q,   run_mvy_d;
    logic              out_valid_q, out_valid_d;
    logic [SAD_W-1:0]  out_mad_q,   out_mad_d;
    logic [MVX_W-1:0]  out_mvx_q,   out_mvx_d;
    logic [MVY_W-1:0]  out_mvy_q,   out_mvy_d;

    logic [SAD_W-1:0]  row_min_s;
    logic [MVX_W-1:0]  row_idx_s;
    logic              accept_s;
    logic              merge_s;

    argmin_row #(
        .NUM_CAND (NUM_CAND),
        .SAD_W    (SAD_W)
    ) u_argmin_row (
        .sad_row_i (sum_row),
        .min_o     (row_min_s),
        .idx_o     (row_idx_s)
    );

    assign accept_s = in_valid && in_ready_q && (state_q == ST_ACCUM);
    // Strictly-less merge: an equal later row never displaces an earlier one.
    assign merge_s  = s1_valid_q && (s1_min_q < run_mad_q);

    // Next-state logic for the control FSM and both pipeline stages.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        in_ready_d  = in_ready_q;
        s1_valid_d  = 1'b0;
        s1_min_d    = s1_min_q;
        s1_idx_d    = s1_idx_q;
        s1_row_d    = s1_row_q;
        run_mad_d   = run_mad_q;
        run_mvx_d   = run_mvx_q;
        run_mvy_d   = run_mvy_q;
        out_valid_d = out_valid_q;
        out_mad_d   = out_mad_q;
        out_mvx_d   = out_mvx_q;
        out_mvy_d   = out_mvy_q;

        if (merge_s) begin
            run_mad_d = s1_min_q;
            run_mvx_d = s1_idx_q;
            run_mvy_d = s1_row_q;
        end else begin
            run_mad_d = run_mad_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ACCUM;
                    row_cnt_d  = {MVY_W{1'b0}};
                    in_ready_d = 1'b1;
                    run_mad_d  = SAD_MAX;
                    run_mvx_d  = {MVX_W{1'b0}};
                    run_mvy_d  = {MVY_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    s1_valid_d = 1'b1;
                    s1_min_d   = row_min_s;
                    s1_idx_d   = row_idx_s;
                    s1_row_d   = row_cnt_q;
                    row_cnt_d  = row_cnt_q + MVY_W'(1);
                    if (row_cnt_q == LAST_ROW) begin
                        state_d    = ST_FLUSH;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                // The final row merges on the first FLUSH edge; publish on the next.
                if (!s1_valid_q) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_mad_d   = run_mad_q;
                    out_mvx_d   = run_mvx_q;
                    out_mvy_d   = run_mvy_q;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_mad_d   = {SAD_W{1'b0}};
                    out_mvx_d   = {MVX_W{1'b0}};
                    out_mvy_d   = {MVY_W{1'b0}};
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                out_mad_d   = {SAD_W{1'b0}};
                out_mvx_d   = {MVX_W{1'b0}};
                out_mvy_d   = {MVY_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset aborts any window in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= {MVY_W{1'b0}};
            in_ready_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_min_q    <= {SAD_W{1'b0}};
            s1_idx_q    <= {MVX_W{1'b0}};
            s1_row_q    <= {MVY_W{1'b0}};
            run_mad_q   <= SAD_MAX;
            run_mvx_q   <= {MVX_W{1'b0}};
            run_mvy_q   <= {MVY_W{1'b0}};
            out_valid_q <= 1'b0;
            out_mad_q   <= {SAD_W{1'b0}};
            out_mvx_q   <= {MVX_W{1'b0}};
            out_mvy_q   <= {MVY_W{1'b0}};
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            in_ready_q  <= in_ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_min_q    <= s1_min_d;
            s1_idx_q    <= s1_idx_d;
            s1_row_q    <= s1_row_d;
            run_mad_q   <= run_mad_d;
            run_mvx_q   <= run_mvx_d;
            run_mvy_q   <= run_mvy_d;
            out_valid_q <= out_valid_d;
            out_mad_q   <= out_mad_d;
            out_mvx_q   <= out_mvx_d;
            out_mvy_q   <= out_mvy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_mad   = out_mad_q;
    assign out_mvx   = out_mvx_q;
    assign out_mvy   = out_mvy_q;

endmodule

// File: tb/tb_mv_select.sv
// Bench for mv_select: default-geometry instance plus a small 8x4x16 instance.
// Expected results come from a row-major first-strict-minimum scan of the window.
module tb_mv_select;

    localparam int NC  = 16;
    localparam int NR  = 16;
    localparam int SW  = 12;
    localparam int NC2 = 8;
    localparam int NR2 = 4;
    localparam int SW2 = 16;

    logic              clk;
    logic              rst_n;
    logic              start, in_valid, in_ready, out_valid, out_ready;
    logic [NC*SW-1:0]  sum_row;
    logic [SW-1:0]     out_mad;
    logic [3:0]        out_mvx, out_mvy;

    logic              start2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [NC2*SW2-1:0] sum_row2;
    logic [SW2-1:0]    out_mad2;
    logic [2:0]        out_mvx2;
    logic [1:0]        out_mvy2;

    int errors = 0;
    int checks = 0;

    logic [SW-1:0]  win  [NR][NC];
    logic [SW2-1:0] win2 [NR2][NC2];
    logic [SW-1:0]  exp_mad;
    logic [3:0]     exp_mvx, exp_mvy;

    mv_select dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .sum_row(sum_row), .out_valid(out_valid),
        .out_ready(out_ready), .out_mad(out_mad), .out_mvx(out_mvx), .out_mvy(out_mvy)
    );

    mv_select #(.NUM_CAND(NC2), .NUM_ROWS(NR2), .SAD_W(SW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
        .in_ready(in_ready2), .sum_row(sum_row2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_mad(out_mad2), .out_mvx(out_mvx2), .out_mvy(out_mvy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NC*SW-1:0] pack_row(input int r);
        logic [NC*SW-1:0] v;
        v = '0;
        for (int k = 0; k < NC; k++) v[k*SW +: SW] = win[r][k];
        return v;
    endfunction

    function automatic logic [NC2*SW2-1:0] pack_row2(input int r);
        logic [NC2*SW2-1:0] v;
        v = '0;
        for (int k = 0; k < NC2; k++) v[k*SW2 +: SW2] = win2[r][k];
        return v;
    endfunction

    // Reference: first occurrence of the global minimum in row-major order.
    task automatic model_main();
        exp_mad = 12'hFFF; exp_mvx = 4'd0; exp_mvy = 4'd0;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < NC; k++)
                if (win[r][k] < exp_mad) begin
                    exp_mad = win[r][k]; exp_mvx = 4'(k); exp_mvy = 4'(r);
                end
    endtask

    // Feed rows 0..nrows-1; returns at the negedge before the final accepting edge.
    task automatic feed_rows(input int nrows, input bit gaps, input string tag);
        int r;
        int cyc;
        bit v;
        r = 0; cyc = 0;
        while (r < nrows && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            sum_row  = pack_row(r);
            if (v && in_ready) r++;
        end
        checks++;
        if (r < nrows) begin
            errors++;
            $display("FAIL %s feed_timeout rows_accepted=%0d required=%0d", tag, r, nrows);
        end
    endtask

    task automatic run_window(input bit gaps, input int hold, input string tag);
        model_main();
        out_ready = (hold == 0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        feed_rows(NR, gaps, tag);
        @(negedge clk); in_valid = 1'b0; sum_row = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid_1 got=%b want=0", tag, out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_flush got=%b want=0", tag, in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid_2 got=%b want=0", tag, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s latency got=%b want=1", tag, out_valid); end
        checks++; if (out_mad !== exp_mad) begin errors++; $display("FAIL %s mad got=%0h want=%0h", tag, out_mad, exp_mad); end
        checks++; if (out_mvx !== exp_mvx) begin errors++; $display("FAIL %s mvx got=%0d want=%0d", tag, out_mvx, exp_mvx); end
        checks++; if (out_mvy !== exp_mvy) begin errors++; $display("FAIL %s mvy got=%0d want=%0d", tag, out_mvy, exp_mvy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_done got=%b want=0", tag, in_ready); end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start = (i == 2 || i == 5);
            checks++;
            if (out_valid !== 1'b1 || out_mad !== exp_mad || out_mvx !== exp_mvx || out_mvy !== exp_mvy) begin
                errors++;
                $display("FAIL %s hold_stable cyc=%0d got=%b/%0h/%0d/%0d want=1/%0h/%0d/%0d",
                         tag, i, out_valid, out_mad, out_mvx, out_mvy, exp_mad, exp_mvx, exp_mvy);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_mad !== 12'd0 || out_mvx !== 4'd0 || out_mvy !== 4'd0) begin
            errors++;
            $display("FAIL %s release got=%b/%0h/%0d/%0d want=0/0/0/0", tag, out_valid, out_mad, out_mvx, out_mvy);
        end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s idle_in_ready got=%b want=0", tag, in_ready); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; sum_row = '0; out_ready = 1'b1;
        start2 = 1'b0; in_valid2 = 1'b0; sum_row2 = '0; out_ready2 = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
        checks++; if (out_mad !== 12'd0) begin errors++; $display("FAIL reset out_mad got=%0h want=0", out_mad); end
        checks++; if (out_mvx !== 4'd0 || out_mvy !== 4'd0) begin errors++; $display("FAIL reset mv got=%0d/%0d want=0/0", out_mvx, out_mvy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready got=%b want=0", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_no_start in_ready got=%b want=0", in_ready); end
    endtask

    task automatic test_directed_min();
        for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) win[r][k] = 12'(100 + r + k);
        win[5][9] = 12'd3;
        run_window(1'b0, 0, "directed");
    endtask

    task automatic test_all_equal();
        for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) win[r][k] = 12'd7;
        run_window(1'b0, 0, "all_equal");
    endtask

    task automatic test_tie_rows();
        for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) win[r][k] = 12'($urandom_range(1, 4095));
        win[2][4] = 12'd0;
        win[11][1] = 12'd0;
        run_window(1'b0, 0, "tie_rows");
    endtask

    task automatic test_all_max();
        for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) win[r][k] = 12'hFFF;
        run_window(1'b0, 0, "all_max");
    endtask

    task automatic test_gaps_hold();
        for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) win[r][k] = 12'(100 + r + k);
        win[5][9] = 12'd3;
        run_window(1'b1, 10, "gaps_hold");
    endtask

    task automatic test_random();
        for (int w = 0; w < 3; w++) begin
            for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) win[r][k] = 12'($urandom_range(0, 63));
            run_window(1'($urandom_range(0, 1)), 0, "random");
        end
    endtask

    task automatic test_abort();
        for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) win[r][k] = 12'(200 + k);
        win[1][3] = 12'd0;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        feed_rows(9, 1'b0, "abort");
        @(negedge clk); in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_mad !== 12'd0 || out_mvx !== 4'd0 || out_mvy !== 4'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs got=%b/%0h/%0d/%0d rdy=%b want=0/0/0/0 rdy=0", out_valid, out_mad, out_mvx, out_mvy, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d got=%b/%b want=0/0", i, out_valid, in_ready);
            end
        end
        for (int r = 0; r < NR; r++) for (int k = 0; k < NC; k++) win[r][k] = 12'($urandom_range(50, 4000));
        win[14][15] = 12'd9;
        run_window(1'b0, 0, "after_abort");
    endtask

    task automatic run_small(input bit all_max, input string tag);
        logic [SW2-1:0] e_mad;
        logic [2:0] e_mvx;
        logic [1:0] e_mvy;
        int r;
        int cyc;
        for (int rr = 0; rr < NR2; rr++) for (int k = 0; k < NC2; k++) win2[rr][k] = 16'hFFFF;
        if (!all_max) win2[3][7] = 16'hFFFE;
        e_mad = 16'hFFFF; e_mvx = 3'd0; e_mvy = 2'd0;
        for (int rr = 0; rr < NR2; rr++)
            for (int k = 0; k < NC2; k++)
                if (win2[rr][k] < e_mad) begin e_mad = win2[rr][k]; e_mvx = 3'(k); e_mvy = 2'(rr); end
        out_ready2 = 1'b1;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        r = 0; cyc = 0;
        while (r < NR2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            in_valid2 = 1'b1;
            sum_row2  = pack_row2(r);
            if (in_ready2) r++;
        end
        checks++; if (r < NR2) begin errors++; $display("FAIL %s feed_timeout rows=%0d want=%0d", tag, r, NR2); end
        @(negedge clk); in_valid2 = 1'b0;
        @(negedge clk);
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL %s early_valid got=%b want=0", tag, out_valid2); end
        @(negedge clk);
        checks++; if (out_valid2 !== 1'b1) begin errors++; $display("FAIL %s latency got=%b want=1", tag, out_valid2); end
        checks++; if (out_mad2 !== e_mad) begin errors++; $display("FAIL %s mad got=%0h want=%0h", tag, out_mad2, e_mad); end
        checks++; if (out_mvx2 !== e_mvx) begin errors++; $display("FAIL %s mvx got=%0d want=%0d", tag, out_mvx2, e_mvx); end
        checks++; if (out_mvy2 !== e_mvy) begin errors++; $display("FAIL %s mvy got=%0d want=%0d", tag, out_mvy2, e_mvy); end
        @(negedge clk);
        checks++; if (out_valid2 !== 1'b0 || out_mad2 !== 16'd0) begin errors++; $display("FAIL %s release got=%b/%0h want=0/0", tag, out_valid2, out_mad2); end
    endtask

    task automatic test_small();
        run_small(1'b0, "small_fffe");
        run_small(1'b1, "small_allmax");
    endtask

    initial begin
        test_reset();
        test_directed_min();
        test_all_equal();
        test_tie_rows();
        test_all_max();
        test_gaps_hold();
        test_random();
        test_abort();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
